// File: rtl/prog_ctrl_pkg.sv
// Purpose: shared types and default constants for the run/program-mode sequencer.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package prog_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_PROG  = 2'b01,
        ST_DRAIN = 2'b10,
        ST_HOLD  = 2'b11
    } prog_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_DRAIN_CYCLES    = 64;
    localparam int DEF_RST_HOLD_CYCLES = 16;
    localparam int DEF_ADR_W           = 15;

    // Minimum time in PROG before the done level is trusted; covers the
    // synchronizer delay so a done left over from a previous session is
    // cleared by the programmer reset before it can be seen.
    localparam int DONE_QUAL_CYCLES = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Purpose: synchronize and debounce a raw board key into a single press pulse.
// Latency: 2 sync cycles + CYCLES stable-high cycles to the (combinational) pulse.
// Backpressure: none; one pulse per press, re-armed only after CYCLES stable-low cycles.
//
// Ports: fpga_clk/fpga_rst_n clock and async active-low reset; key_raw is the
// asynchronous key level; press_pls is high for exactly one cycle per accepted press.
module key_debounce #(
    parameter int CYCLES = 4
) (
    input  logic fpga_clk,
    input  logic fpga_rst_n,
    input  logic key_raw,
    output logic press_pls
);

    localparam int CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [1:0]    sync_q;
    logic          armed_q;
    logic [CW-1:0] cnt_q;
    logic          key_s;
    logic          phase_match;

    assign key_s = sync_q[1];

    // While armed we count stable-high cycles toward a press; once fired we
    // count stable-low cycles toward re-arming. Any other level restarts.
    assign phase_match = armed_q ? key_s : ~key_s;
    assign press_pls   = armed_q & key_s & (cnt_q == LAST);

    always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
        if (!fpga_rst_n) begin
            sync_q  <= 2'b00;
            armed_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync_q <= {sync_q[0], key_raw};
            if (!phase_match) begin
                cnt_q <= '0;
            end else if (cnt_q == LAST) begin
                cnt_q   <= '0;
                armed_q <= ~armed_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/prog_mode_ctrl.sv
// Purpose: choose between CPU execution and UART download; sequence the two resets.
// Latency: key 2+DEBOUNCE_CYCLES+1 to PROG; done 3 to DRAIN; DRAIN_CYCLES+RST_HOLD_CYCLES to CPU release.
// Backpressure: none; programmer writes are gated, never stalled.
//
// Ports: fpga_clk, fpga_rst_n (async active-low); start_pg_i raw key; upg_done_i,
// upg_wen_i, upg_adr_i from the UART programmer; upg_rst_o / cpu_rst_o active-high
// resets; rom_upg_wen_o / ram_upg_wen_o gated write enables; prog_busy_o LED;
// word_cnt_o words written in the current download.
module prog_mode_ctrl
    import prog_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int DRAIN_CYCLES    = DEF_DRAIN_CYCLES,
    parameter int RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
    parameter int ADR_W           = DEF_ADR_W
) (
    input  logic             fpga_clk,
    input  logic             fpga_rst_n,
    input  logic             start_pg_i,
    input  logic             upg_done_i,
    input  logic             upg_wen_i,
    input  logic [ADR_W-1:0] upg_adr_i,
    output logic             upg_rst_o,
    output logic             cpu_rst_o,
    output logic             rom_upg_wen_o,
    output logic             ram_upg_wen_o,
    output logic             prog_busy_o,
    output logic [ADR_W-1:0] word_cnt_o
);

    localparam int CNT_W = $clog2(max3(DRAIN_CYCLES, RST_HOLD_CYCLES, DONE_QUAL_CYCLES) + 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] QUAL_LAST  = CNT_W'(DONE_QUAL_CYCLES - 1);

    prog_state_e      state_q;
    prog_state_e      state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       done_sync_q;
    logic [1:0]       wen_sync_q;
    logic             wen_prev_q;
    logic [ADR_W-1:0] word_cnt_q;

    logic press;
    logic done_s;
    logic wen_rise;
    logic busy;
    logic adr_lo_unused;

    key_debounce #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .fpga_clk   (fpga_clk),
        .fpga_rst_n (fpga_rst_n),
        .key_raw    (start_pg_i),
        .press_pls  (press)
    );

    assign done_s   = done_sync_q[1];
    assign wen_rise = wen_sync_q[1] & ~wen_prev_q;

    // Only the bank-select bit is decoded here; the word offset goes straight
    // to the memories.
    assign adr_lo_unused = ^upg_adr_i[ADR_W-2:0];

    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        cpu_rst_o = 1'b1;
        upg_rst_o = 1'b1;
        unique case (state_q)
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                cpu_rst_o = 1'b0;
                if (press) state_d = ST_PROG;
            end
            ST_PROG: begin
                busy      = 1'b1;
                upg_rst_o = 1'b0;
                // Completion wins over a simultaneous abort press.
                if (done_s && (cnt_q >= QUAL_LAST)) state_d = ST_DRAIN;
                else if (press)                     state_d = ST_HOLD;
            end
            ST_DRAIN: begin
                busy      = 1'b1;
                upg_rst_o = 1'b0;
                if (cnt_q == DRAIN_LAST) state_d = ST_HOLD;
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    assign prog_busy_o   = busy;
    assign rom_upg_wen_o = upg_wen_i & ~upg_adr_i[ADR_W-1] & busy;
    assign ram_upg_wen_o = upg_wen_i &  upg_adr_i[ADR_W-1] & busy;
    assign word_cnt_o    = word_cnt_q;

    always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
        if (!fpga_rst_n) begin
            state_q     <= ST_HOLD;
            cnt_q       <= '0;
            done_sync_q <= 2'b00;
            wen_sync_q  <= 2'b00;
            wen_prev_q  <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            done_sync_q <= {done_sync_q[0], upg_done_i};
            wen_sync_q  <= {wen_sync_q[0], upg_wen_i};
            wen_prev_q  <= wen_sync_q[1];

            // One timer shared by DRAIN and HOLD; it also measures time spent
            // in PROG for done qualification, so it saturates instead of wrapping.
            if (state_d != state_q)   cnt_q <= '0;
            else if (cnt_q != '1)     cnt_q <= cnt_q + 1'b1;

            if ((state_d == ST_PROG) && (state_q != ST_PROG)) begin
                word_cnt_q <= '0;
            end else if ((state_q == ST_PROG) && wen_rise && (word_cnt_q != '1)) begin
                word_cnt_q <= word_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prog_mode_ctrl.sv
// Purpose: self-checking bench for prog_mode_ctrl against a behavioural mode model.
// Latency: n/a.
// Backpressure: n/a.
module tb_prog_mode_ctrl;

    localparam int DB   = 4;
    localparam int DR   = 8;
    localparam int RH   = 16;
    localparam int AW   = 15;
    localparam int QUAL = 4;

    logic          fpga_clk   = 1'b0;
    logic          fpga_rst_n = 1'b0;
    logic          start_pg_i = 1'b0;
    logic          upg_done_i = 1'b0;
    logic          upg_wen_i  = 1'b0;
    logic [AW-1:0] upg_adr_i  = '0;
    logic          upg_rst_o;
    logic          cpu_rst_o;
    logic          rom_upg_wen_o;
    logic          ram_upg_wen_o;
    logic          prog_busy_o;
    logic [AW-1:0] word_cnt_o;

    int tests_run    = 0;
    int tests_failed = 0;
    int rom_pulses   = 0;
    int ram_pulses   = 0;

    prog_mode_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .DRAIN_CYCLES    (DR),
        .RST_HOLD_CYCLES (RH),
        .ADR_W           (AW)
    ) dut (
        .fpga_clk      (fpga_clk),
        .fpga_rst_n    (fpga_rst_n),
        .start_pg_i    (start_pg_i),
        .upg_done_i    (upg_done_i),
        .upg_wen_i     (upg_wen_i),
        .upg_adr_i     (upg_adr_i),
        .upg_rst_o     (upg_rst_o),
        .cpu_rst_o     (cpu_rst_o),
        .rom_upg_wen_o (rom_upg_wen_o),
        .ram_upg_wen_o (ram_upg_wen_o),
        .prog_busy_o   (prog_busy_o),
        .word_cnt_o    (word_cnt_o)
    );

    always #5 fpga_clk = ~fpga_clk;

    // Reference model: modes with time-in-mode, raw-sample histories for the
    // two-stage synchronizers and a window of synchronized key samples.
    typedef enum int {M_RUN, M_PROG, M_DRAIN, M_HOLD} mode_t;

    mode_t m_mode = M_HOLD;
    mode_t m_next;
    int    m_age   = 0;
    int    m_words = 0;
    bit    m_armed = 1'b1;
    bit    m_wen_prev = 1'b0;
    bit    raw_key[$];
    bit    raw_done[$];
    bit    raw_wen[$];
    bit    key_win[$];
    bit    k_now, d_now, w_now, m_press;
    int    ones;

    always @(posedge fpga_clk or negedge fpga_rst_n) begin
        if (!fpga_rst_n) begin
            m_mode = M_HOLD; m_age = 0; m_words = 0; m_armed = 1'b1; m_wen_prev = 1'b0;
            raw_key.delete(); raw_done.delete(); raw_wen.delete(); key_win.delete();
        end else begin
            // value held by the second sync stage during the cycle ending now
            k_now = (raw_key.size()  >= 2) ? raw_key[raw_key.size()-2]   : 1'b0;
            d_now = (raw_done.size() >= 2) ? raw_done[raw_done.size()-2] : 1'b0;
            w_now = (raw_wen.size()  >= 2) ? raw_wen[raw_wen.size()-2]   : 1'b0;
            raw_key.push_back(start_pg_i);  if (raw_key.size()  > 2) void'(raw_key.pop_front());
            raw_done.push_back(upg_done_i); if (raw_done.size() > 2) void'(raw_done.pop_front());
            raw_wen.push_back(upg_wen_i);   if (raw_wen.size()  > 2) void'(raw_wen.pop_front());

            key_win.push_back(k_now);
            if (key_win.size() > DB) void'(key_win.pop_front());
            m_press = 1'b0;
            if (key_win.size() == DB) begin
                ones = 0;
                foreach (key_win[i]) ones += int'(key_win[i]);
                if (m_armed && ones == DB) begin
                    m_press = 1'b1;
                    m_armed = 1'b0;
                end else if (!m_armed && ones == 0) begin
                    m_armed = 1'b1;
                end
            end

            m_next = m_mode;
            case (m_mode)
                M_HOLD:  if (m_age == RH - 1) m_next = M_RUN;
                M_RUN:   if (m_press) m_next = M_PROG;
                M_PROG:  if (d_now && m_age >= QUAL - 1) m_next = M_DRAIN;
                         else if (m_press) m_next = M_HOLD;
                M_DRAIN: if (m_age == DR - 1) m_next = M_HOLD;
                default: m_next = M_HOLD;
            endcase

            if (m_mode == M_PROG && w_now && !m_wen_prev && m_words < (2**AW) - 1) m_words++;
            m_wen_prev = w_now;
            if (m_next == M_PROG && m_mode != M_PROG) m_words = 0;
            m_age  = (m_next != m_mode) ? 0 : m_age + 1;
            m_mode = m_next;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        bit busy;
        busy = (m_mode == M_PROG) || (m_mode == M_DRAIN);
        chk({tag, ".cpu_rst"},  32'(cpu_rst_o),   32'(m_mode != M_RUN));
        chk({tag, ".upg_rst"},  32'(upg_rst_o),   32'(!busy));
        chk({tag, ".busy"},     32'(prog_busy_o), 32'(busy));
        chk({tag, ".word_cnt"}, 32'(word_cnt_o),  32'(m_words));
        chk({tag, ".rom_wen"},  32'(rom_upg_wen_o), 32'(upg_wen_i & ~upg_adr_i[AW-1] & busy));
        chk({tag, ".ram_wen"},  32'(ram_upg_wen_o), 32'(upg_wen_i &  upg_adr_i[AW-1] & busy));
    endtask

    task automatic tick(input string tag);
        @(posedge fpga_clk);
        @(negedge fpga_clk);
        check_outputs(tag);
        if (rom_upg_wen_o) rom_pulses++;
        if (ram_upg_wen_o) ram_pulses++;
    endtask

    task automatic ticks(input int n, input string tag);
        repeat (n) tick(tag);
    endtask

    task automatic key_press(input int hi, input int lo, input string tag);
        start_pg_i = 1'b1; ticks(hi, tag);
        start_pg_i = 1'b0; ticks(lo, tag);
    endtask

    task automatic do_write(input logic [AW-1:0] adr);
        upg_adr_i = adr; upg_wen_i = 1'b1; tick("write");
        upg_wen_i = 1'b0; ticks(2, "write_gap");
    endtask

    int n;

    initial begin
        // reset state
        ticks(3, "in_reset");
        chk("rst.cpu_rst", 32'(cpu_rst_o), 32'd1);
        chk("rst.upg_rst", 32'(upg_rst_o), 32'd1);
        chk("rst.busy",    32'(prog_busy_o), 32'd0);
        chk("rst.words",   32'(word_cnt_o), 32'd0);

        // reset release: CPU held for exactly RH cycles
        fpga_rst_n = 1'b1;
        n = 0;
        while (cpu_rst_o && n < 100) begin
            tick("release");
            n++;
            if (!upg_rst_o) chk("release.upg_rst", 32'(upg_rst_o), 32'd1);
        end
        chk("release.hold_cycles", 32'(n), 32'(RH));

        // bouncy key must not start programming
        key_press(3, 1, "bounce");
        key_press(3, 8, "bounce");
        chk("bounce.busy", 32'(prog_busy_o), 32'd0);
        chk("bounce.cpu_rst", 32'(cpu_rst_o), 32'd0);

        // clean press enters PROG
        key_press(6, 0, "press");
        chk("press.busy", 32'(prog_busy_o), 32'd1);
        chk("press.upg_rst", 32'(upg_rst_o), 32'd0);
        chk("press.cpu_rst", 32'(cpu_rst_o), 32'd1);
        ticks(6, "rearm");

        // routing and count
        rom_pulses = 0; ram_pulses = 0;
        repeat (5) do_write(15'h0003);
        repeat (2) do_write(15'h4001);
        ticks(4, "settle");
        chk("route.rom_pulses", 32'(rom_pulses), 32'd5);
        chk("route.ram_pulses", 32'(ram_pulses), 32'd2);
        chk("route.word_cnt",   32'(word_cnt_o), 32'd7);

        // completion: DRAIN after 3, HOLD 8 later, CPU released 16 after that
        upg_done_i = 1'b1;
        n = 0;
        while (!upg_rst_o && n < 100) begin tick("done"); n++; end
        chk("done.to_hold", 32'(n), 32'(3 + DR));
        while (cpu_rst_o && n < 200) begin tick("done"); n++; end
        chk("done.to_release", 32'(n), 32'(3 + DR + RH));
        chk("done.word_cnt", 32'(word_cnt_o), 32'd7);

        // a write while running is blocked
        upg_wen_i = 1'b1; upg_adr_i = 15'h0003; #1;
        chk("run.rom_wen", 32'(rom_upg_wen_o), 32'd0);
        upg_adr_i = 15'h4001; #1;
        chk("run.ram_wen", 32'(ram_upg_wen_o), 32'd0);
        tick("run_write");
        upg_wen_i = 1'b0; ticks(3, "run_idle");

        // stale done still high: entry works, download ends after qualification
        key_press(6, 0, "stale");
        chk("stale.busy", 32'(prog_busy_o), 32'd1);
        ticks(40, "stale_run");
        upg_done_i = 1'b0;
        start_pg_i = 1'b0; ticks(6, "idle");

        // abort without done
        key_press(6, 6, "abort_enter");
        do_write(15'h0010);
        key_press(6, 0, "abort");
        chk("abort.upg_rst", 32'(upg_rst_o), 32'd1);
        chk("abort.busy",    32'(prog_busy_o), 32'd0);
        ticks(RH + 6, "abort_hold");

        // press and done arriving together: done wins
        key_press(6, 6, "prio_enter");
        ticks(4, "prio_wait");
        start_pg_i = 1'b1; ticks(3, "prio");
        upg_done_i = 1'b1; ticks(3, "prio");
        chk("prio.upg_rst", 32'(upg_rst_o), 32'd0);
        chk("prio.busy",    32'(prog_busy_o), 32'd1);
        start_pg_i = 1'b0;
        ticks(DR + RH + 6, "prio_drain");
        upg_done_i = 1'b0; ticks(6, "idle");

        // randomized key/write/done traffic
        for (int seg = 0; seg < 200; seg++) begin
            int len;
            start_pg_i = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) upg_done_i = ~upg_done_i;
            len = $urandom_range(1, 9);
            for (int c = 0; c < len; c++) begin
                upg_wen_i = ($urandom_range(0, 3) == 0);
                upg_adr_i = AW'($urandom);
                tick("rand");
            end
        end
        upg_wen_i = 1'b0; upg_done_i = 1'b0; start_pg_i = 1'b0;
        ticks(RH + DR + 10, "rand_quiet");

        // async reset in the middle of DRAIN
        key_press(6, 6, "ar_enter");
        do_write(15'h0001);
        ticks(3, "ar_settle");
        upg_done_i = 1'b1;
        ticks(5, "ar_drain");
        chk("ar.in_drain", 32'(prog_busy_o), 32'd1);
        upg_wen_i = 1'b1; upg_adr_i = 15'h0002;
        #2 fpga_rst_n = 1'b0;
        #1;
        chk("ar.busy",    32'(prog_busy_o), 32'd0);
        chk("ar.words",   32'(word_cnt_o), 32'd0);
        chk("ar.cpu_rst", 32'(cpu_rst_o), 32'd1);
        chk("ar.upg_rst", 32'(upg_rst_o), 32'd1);
        chk("ar.rom_wen", 32'(rom_upg_wen_o), 32'd0);
        upg_wen_i = 1'b0; upg_done_i = 1'b0;
        @(negedge fpga_clk);
        fpga_rst_n = 1'b1;
        ticks(RH + 4, "ar_release");
        chk("ar.running", 32'(cpu_rst_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
